// File: rtl/data_sram_responder.sv
// data_sram_responder: data-side memory endpoint for standalone pipeline benches.
// A word-addressed RAM with byte strobes sits behind an in-order response
// queue. Each accepted request gets one data_ok pulse, no earlier than
// LATENCY cycles after acceptance. A request is accepted on a clock edge
// only when req && addr_ok. A response is delivered in any cycle where
// data_ok is high, and the master must take it then. There is no response
// ready, so resp_hold is the only way to stretch the response phase.
module data_sram_responder #(
  parameter int ADDR_W          = 10,
  parameter int MAX_OUTSTANDING = 4,
  parameter int LATENCY         = 2
) (
  input  logic                                     clk,
  input  logic                                     resetn,
  input  logic                                     req,
  input  logic                                     wr,
  input  logic [31:0]                              addr,
  input  logic [3:0]                               wstrb,
  input  logic [31:0]                              wdata,
  output logic                                     addr_ok,
  output logic                                     data_ok,
  output logic [31:0]                              rdata,
  input  logic                                     addr_hold,
  input  logic                                     resp_hold,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int AGE_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  logic [31:0]       mem    [2**ADDR_W];
  logic [31:0]       q_data [MAX_OUTSTANDING];
  logic              q_wr   [MAX_OUTSTANDING];
  logic [AGE_W-1:0]  q_age  [MAX_OUTSTANDING];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [ADDR_W-1:0] word_idx;
  logic              accept;
  logic              unused_addr_bits;

  assign word_idx         = addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{addr[31:ADDR_W+2], addr[1:0]};

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // A response in the same cycle never frees a slot for acceptance here:
  // addr_ok looks only at the registered count.
  assign addr_ok = !addr_hold && (outstanding < OUT_W'(MAX_OUTSTANDING));
  assign accept  = req && addr_ok;
  assign data_ok = (outstanding != '0) && (q_age[rd_ptr] == '0) && !resp_hold;
  assign rdata   = (data_ok && !q_wr[rd_ptr]) ? q_data[rd_ptr] : 32'h0;

  // RAM write port: strobed bytes updated at the accepting edge; never reset.
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Queue payload: every entry ages toward 0 each cycle, and a new entry
  // captures the read word, which already reflects earlier writes.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (q_age[i] != '0) q_age[i] <= q_age[i] - 1'b1;
    end
    if (accept) begin
      q_wr[wr_ptr]   <= wr;
      q_data[wr_ptr] <= wr ? 32'h0 : mem[word_idx];
      q_age[wr_ptr]  <= AGE_W'(LATENCY - 1);
    end
  end

  // Queue control: pointers and occupancy. Reset discards in-flight entries.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
    end else begin
      if (accept)  wr_ptr <= ptr_inc(wr_ptr);
      if (data_ok) rd_ptr <= ptr_inc(rd_ptr);
      case ({accept, data_ok})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder. Drivers push expected responses
// into a scoreboard, and an independent monitor pops them on data_ok.
module tb_data_sram_responder;

  localparam int ADDR_W  = 10;
  localparam int MAXO    = 4;
  localparam int LATENCY = 2;
  localparam int OUT_W   = $clog2(MAXO + 1);

  logic             clk = 1'b0;
  logic             resetn;
  logic             req, wr;
  logic [31:0]      addr, wdata;
  logic [3:0]       wstrb;
  logic             addr_ok, data_ok;
  logic [31:0]      rdata;
  logic             addr_hold, resp_hold;
  logic [OUT_W-1:0] outstanding;

  data_sram_responder #(
    .ADDR_W(ADDR_W), .MAX_OUTSTANDING(MAXO), .LATENCY(LATENCY)
  ) dut (
    .clk(clk), .resetn(resetn), .req(req), .wr(wr), .addr(addr),
    .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok),
    .rdata(rdata), .addr_hold(addr_hold), .resp_hold(resp_hold),
    .outstanding(outstanding)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard
  logic [31:0] exp_q[$];
  int          due_q[$];
  bit          exact_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every data_ok must match the oldest expectation.
  always @(negedge clk) begin
    if (resetn && data_ok) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_response: got data_ok rdata 0x%08h expected none (cycle %0d)", rdata, cyc);
      end else begin
        logic [31:0] e;
        int          d;
        bit          x;
        e = exp_q.pop_front();
        d = due_q.pop_front();
        x = exact_q.pop_front();
        check32("rdata", rdata, e);
        if (x) check_int("resp_cycle", cyc, d);
        else begin
          n_cmp++;
          if (cyc < d) begin
            n_err++;
            $display("FAIL resp_early: got cycle %0d expected >= %0d", cyc, d);
          end
        end
      end
    end
  end

  // Driver: present a request until accepted, recording its expectation.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input logic [31:0] exp_r,
                        input bit exact, output int waits);
    bit done;
    waits = 0;
    done  = 0;
    req = 1'b1; wr = w; addr = a; wstrb = s; wdata = d;
    while (!done) begin
      @(negedge clk);
      if (addr_ok) begin
        exp_q.push_back(exp_r);
        due_q.push_back(cyc + LATENCY);
        exact_q.push_back(exact);
        @(posedge clk); #1;
        done = 1;
      end else begin
        waits++;
        if (waits > 50) begin
          n_cmp++;
          n_err++;
          $display("FAIL accept_timeout: got no addr_ok after %0d cycles expected acceptance", waits);
          done = 1;
        end else begin
          @(posedge clk); #1;
        end
      end
    end
    req = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    check_int("drain_pending", exp_q.size(), 0);
  endtask

  int w;
  int wsum;

  initial begin
    resetn = 1'b0; req = 1'b0; wr = 1'b0; addr = '0; wstrb = '0; wdata = '0;
    addr_hold = 1'b0; resp_hold = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_int("rst_outstanding", int'(outstanding), 0);
    check_int("rst_data_ok", int'(data_ok), 0);
    check_int("rst_addr_ok", int'(addr_ok), 1);
    addr_hold = 1'b1;
    #1 check_int("rst_addr_ok_hold", int'(addr_ok), 0);
    addr_hold = 1'b0;
    @(posedge clk); #1 resetn = 1'b1;

    // Single write then read
    do_req(1'b1, 32'h40, 4'hF, 32'h1122_3344, 32'h0, 1'b1, w);
    do_req(1'b0, 32'h40, 4'h0, 32'h0, 32'h1122_3344, 1'b1, w);
    drain();

    // Byte strobes
    do_req(1'b1, 32'h80, 4'hF, 32'hAABB_CCDD, 32'h0, 1'b1, w);
    do_req(1'b1, 32'h80, 4'b0101, 32'h1122_3344, 32'h0, 1'b1, w);
    do_req(1'b0, 32'h80, 4'h0, 32'h0, 32'hAA22_CC44, 1'b1, w);
    drain();

    // Preload 0..7 then back-to-back reads
    for (int i = 0; i < 8; i++) do_req(1'b1, 32'(4*i), 4'hF, 32'(i), 32'h0, 1'b1, w);
    drain();
    wsum = 0;
    for (int i = 0; i < 8; i++) begin
      do_req(1'b0, 32'(4*i), 4'h0, 32'h0, 32'(i), 1'b1, w);
      wsum += w;
    end
    check_int("b2b_accept_stalls", wsum, 0);
    drain();

    // addr_hold blocks acceptance
    addr_hold = 1'b1;
    @(negedge clk);
    check_int("addr_hold_addr_ok", int'(addr_ok), 0);
    @(posedge clk); #1 addr_hold = 1'b0;

    // Full and hold
    resp_hold = 1'b1;
    for (int i = 0; i < 4; i++) do_req(1'b0, 32'(4*i), 4'h0, 32'h0, 32'(i), 1'b0, w);
    req = 1'b1; wr = 1'b0; addr = 32'h10;
    @(negedge clk);
    check_int("full_outstanding", int'(outstanding), 4);
    check_int("full_addr_ok", int'(addr_ok), 0);
    check_int("full_held_data_ok", int'(data_ok), 0);
    @(posedge clk); #1 resp_hold = 1'b0;
    @(negedge clk);
    check_int("release_data_ok", int'(data_ok), 1);
    check_int("release_addr_ok", int'(addr_ok), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check_int("refill_addr_ok", int'(addr_ok), 1);
    exp_q.push_back(32'h4);
    due_q.push_back(cyc + LATENCY);
    exact_q.push_back(1'b0);
    @(posedge clk); #1 req = 1'b0;
    drain();

    // Read-after-write in consecutive cycles
    do_req(1'b1, 32'h100, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b1, w);
    do_req(1'b0, 32'h100, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b1, w);
    drain();

    // Asynchronous reset with three requests in flight
    resp_hold = 1'b1;
    do_req(1'b0, 32'h40, 4'h0, 32'h0, 32'h1122_3344, 1'b0, w);
    do_req(1'b0, 32'h80, 4'h0, 32'h0, 32'hAA22_CC44, 1'b0, w);
    do_req(1'b0, 32'h100, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b0, w);
    @(negedge clk);
    check_int("pre_reset_outstanding", int'(outstanding), 3);
    #2 resetn = 1'b0;
    exp_q.delete(); due_q.delete(); exact_q.delete();
    #1;
    check_int("async_rst_outstanding", int'(outstanding), 0);
    check_int("async_rst_data_ok", int'(data_ok), 0);
    check32("async_rst_rdata", rdata, 32'h0);
    check_int("async_rst_addr_ok", int'(addr_ok), 1);
    resp_hold = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (6) @(posedge clk);
    #1 check_int("post_rst_outstanding", int'(outstanding), 0);
    do_req(1'b0, 32'h100, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b1, w);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
